// File: rtl/barrel_shift_sweep_checker.sv
// rtl/barrel_shift_sweep_checker.sv - on-board rotation sweep checker for the barrel-shifter stage
module barrel_shift_sweep_checker #(
  parameter int WIDTH       = 16,
  parameter int SHW         = 5,
  parameter int SETTLE      = 2,
  parameter int ROTATE_LEFT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] led_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [SHW-1:0]   shift_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SHW-1:0]   err_count,
  output logic [SHW-1:0]   first_err_shift
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    settle_cnt;
  logic [SHW-1:0]   index;
  int               rot_amt;
  logic [WIDTH-1:0] expected;
  logic             mismatch;
  logic             last_step;
  logic [SHW-1:0]   err_inc;

  // Expected shifter output for the current step, plus the compare result
  always_comb begin
    rot_amt  = int'(index) % WIDTH;
    expected = '0;
    if (ROTATE_LEFT != 0) begin
      expected = (sw_out << rot_amt) | (sw_out >> (WIDTH - rot_amt));
    end else begin
      expected = (sw_out >> rot_amt) | (sw_out << (WIDTH - rot_amt));
    end
    mismatch  = (led_in != expected);
    last_step = (index == SHW'(WIDTH - 1));
    err_inc   = (err_count == '1) ? err_count : err_count + SHW'(1);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: settle, check, repeat per shift, then one DONE cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt == CW'(SETTLE - 1)) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = last_step ? S_DONE : S_SETTLE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Sweep datapath: latch pattern, step shift amount, accumulate mismatches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_out          <= '0;
      shift_out       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_shift <= '0;
      settle_cnt      <= '0;
      index           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sw_out          <= pattern;
            shift_out       <= '0;
            index           <= '0;
            busy            <= 1'b1;
            err_count       <= '0;
            first_err_shift <= '0;
            pass            <= 1'b0;
            settle_cnt      <= '0;
          end
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt + CW'(1);
        end
        S_CHECK: begin
          if (mismatch) begin
            err_count <= err_inc;
            if (err_count == '0) first_err_shift <= index;
          end
          if (!last_step) begin
            index      <= index + SHW'(1);
            shift_out  <= index + SHW'(1);
            settle_cnt <= '0;
          end else begin
            done <= 1'b1;
            pass <= mismatch ? 1'b0 : (err_count == '0);
          end
        end
        S_DONE: begin
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_shift_sweep_checker.sv
// tb/tb_barrel_shift_sweep_checker.sv - scoreboard bench for barrel_shift_sweep_checker
module tb_barrel_shift_sweep_checker;

  localparam int W     = 16;
  localparam int SW    = 5;
  localparam int ST    = 2;
  localparam int SWEEP = W * (ST + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  pattern;
  logic [W-1:0]  led_in = '0;
  logic [W-1:0]  sw_out;
  logic [SW-1:0] shift_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic [SW-1:0] err_count;
  logic [SW-1:0] first_err_shift;

  barrel_shift_sweep_checker #(
    .WIDTH(W), .SHW(SW), .SETTLE(ST), .ROTATE_LEFT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .led_in(led_in),
    .sw_out(sw_out), .shift_out(shift_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_shift(first_err_shift)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [W-1:0] pat;
    int           errs;
    int           first;
    bit           pass;
    int           done_cyc;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  exp_t mon_e;

  // Shifter fault model: 0 ideal, 1 stuck value, 2 corrupt one shift, 3 corrupt a shift mask
  int           mode = 0;
  logic [W-1:0] stuck_val = '0;
  int           corrupt_k = 0;
  logic [W-1:0] corrupt_mask = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Rotate left as arithmetic: x*2^s split into the part above and below 2^16, then summed
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int s);
    longint prod;
    prod = longint'(x) * (longint'(1) << (s % W));
    return W'((prod % 65536) + (prod / 65536));
  endfunction

  function automatic logic [W-1:0] model_led(input logic [W-1:0] x, input int s);
    case (mode)
      1:       return stuck_val;
      2:       return (s == corrupt_k) ? (rotl(x, s) ^ 16'h0100) : rotl(x, s);
      3:       return corrupt_mask[s % W] ? (rotl(x, s) ^ 16'h0001) : rotl(x, s);
      default: return rotl(x, s);
    endcase
  endfunction

  function automatic exp_t build(input logic [W-1:0] p, input int done_cyc);
    exp_t e;
    e.pat = p;
    e.errs = 0;
    e.first = 0;
    e.done_cyc = done_cyc;
    for (int s = 0; s < W; s++) begin
      if (model_led(p, s) != rotl(p, s)) begin
        if (e.errs == 0) e.first = s;
        e.errs++;
      end
    end
    e.pass = (e.errs == 0);
    return e;
  endfunction

  // Shifter under test, settling half a cycle after the checker's drive changes
  always @(negedge clk) led_in = model_led(sw_out, int'(shift_out));

  // Monitor: every done pulse must match the oldest outstanding sweep
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got done=1, expected no pulse (cycle %0d)", cyc);
        end else begin
          mon_e = q.pop_front();
          check("done_cycle", cyc, mon_e.done_cyc);
          check("err_count", err_count, mon_e.errs);
          check("first_err_shift", first_err_shift, mon_e.first);
          check("pass", pass, mon_e.pass);
          check("sw_out_latched", sw_out, mon_e.pat);
          check("busy_in_done", busy, 1);
          last_exp = mon_e;
        end
      end else if (q.size() != 0 && cyc > q[0].done_cyc) begin
        check("done_missing", cyc, q[0].done_cyc);
        void'(q.pop_front());
      end
    end
  end

  task automatic start_sweep(input logic [W-1:0] p, output int n);
    @(negedge clk);
    pattern = p;
    start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    q.push_back(build(p, n + SWEEP));
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || busy === 1'b1) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("idle_timeout", t, 0);
  endtask

  task automatic check_persist();
    repeat (3) @(negedge clk);
    check("persist_err", err_count, last_exp.errs);
    check("persist_first", first_err_shift, last_exp.first);
    check("persist_pass", pass, last_exp.pass);
    check("persist_sw", sw_out, last_exp.pat);
    check("persist_busy", busy, 0);
  endtask

  task automatic run_simple(input int m, input logic [W-1:0] p);
    int n;
    mode = m;
    start_sweep(p, n);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check_persist();
  endtask

  initial begin
    int n;
    int t;
    rst_n = 1'b0;
    start = 1'b0;
    pattern = '0;
    repeat (2) @(negedge clk);
    check("rst_sw", sw_out, 0);
    check("rst_shift", shift_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_first", first_err_shift, 0);
    rst_n = 1'b1;

    // Ideal shifter, shift amount stepping every SETTLE+1 cycles
    mode = 0;
    start_sweep(16'h0001, n);
    @(negedge clk);
    start = 1'b0;
    check("t1_shift0", shift_out, 0);
    check("t1_busy", busy, 1);
    for (int k = 1; k < W; k++) begin
      repeat (3) @(negedge clk);
      check($sformatf("t1_shift%0d", k), shift_out, k);
    end
    wait_idle();
    check_persist();

    // Stuck shifter output and single-shift corruption
    stuck_val = 16'h0001;
    run_simple(1, 16'h0001);
    run_simple(0, 16'hFFFE);
    corrupt_k = 2;
    run_simple(2, 16'hFFFE);
    stuck_val = 16'hFD55;
    run_simple(1, 16'hFD55);

    // Start and pattern changes while busy must not disturb the sweep
    mode = 0;
    start_sweep(16'hA5C3, n);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    pattern = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_sw_hold", sw_out, 16'hA5C3);
    wait_idle();

    // Asynchronous reset mid-sweep, then a fresh sweep from shift 0
    mode = 2;
    corrupt_k = 3;
    start_sweep(16'h00F0, n);
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (shift_out !== SW'(7) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("t6_reach7_timeout", t, 0);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("t6_busy", busy, 0);
    check("t6_shift", shift_out, 0);
    check("t6_err", err_count, 0);
    check("t6_first", first_err_shift, 0);
    check("t6_done", done, 0);
    check("t6_sw", sw_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    start_sweep(16'h00F0, n);
    @(negedge clk);
    start = 1'b0;
    check("t6_restart_shift", shift_out, 0);
    wait_idle();
    check_persist();

    // Start held high through DONE is re-accepted one IDLE cycle later
    mode = 0;
    start_sweep(16'h8001, n);
    q.push_back(build(16'h8001, n + SWEEP + 2 + SWEEP));
    t = 0;
    while (cyc < n + SWEEP + 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    wait_idle();

    // Randomised patterns and fault masks
    for (int r = 0; r < 6; r++) begin
      corrupt_mask = W'($urandom);
      if (r == 0) corrupt_mask = '0;
      run_simple(3, W'($urandom));
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
